// File: rtl/i2c_cfg_target.sv
// rtl/i2c_cfg_target.sv - I2C target bridging host bus cycles to single-cycle register strobes
module i2c_cfg_target #(
    parameter logic [6:0] I2C_ADDR    = 7'h50,
    parameter int         REG_ADDR_SZ = 2
) (
    input  logic                   hsclk,
    input  logic                   resetb,
    input  logic                   scl_in,
    input  logic                   sda_in,
    output logic                   sda_oe,
    output logic [REG_ADDR_SZ-1:0] reg_addr,
    output logic [7:0]             reg_wdata,
    output logic                   reg_wr,
    output logic                   reg_rd,
    input  logic [7:0]             reg_rdata,
    output logic                   busy
);

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_ADDR       = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK   = 4'd2;
    localparam logic [3:0] ST_PTR        = 4'd3;
    localparam logic [3:0] ST_PTR_ACK    = 4'd4;
    localparam logic [3:0] ST_WDATA      = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK  = 4'd6;
    localparam logic [3:0] ST_RDATA      = 4'd7;
    localparam logic [3:0] ST_RDATA_MACK = 4'd8;
    localparam logic [3:0] ST_WAIT       = 4'd9;

    localparam logic [REG_ADDR_SZ-1:0] PTR_ONE = 1;

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    // Idle bus is high, so the synchronizers reset to 1 to avoid false edges at release
    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;

    // SDA edges are qualified by the previous SCL level so a START landing on an SCL-fall cycle still wins
    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_d & ~sda_d & sda_s2;

    logic [3:0]             state;
    logic [2:0]             bitcnt;
    logic                   byte_full;
    logic [7:0]             shift;
    logic                   rw_bit;
    logic                   mstr_ack;
    logic [REG_ADDR_SZ-1:0] ptr;

    assign reg_addr = ptr;

    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            state     <= ST_IDLE;
            bitcnt    <= 3'd0;
            byte_full <= 1'b0;
            shift     <= 8'h00;
            rw_bit    <= 1'b0;
            mstr_ack  <= 1'b0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            reg_wdata <= 8'h00;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            if (reg_wr) begin
                ptr <= ptr + PTR_ONE;
            end

            if (start_det) begin
                state     <= ST_ADDR;
                bitcnt    <= 3'd0;
                byte_full <= 1'b0;
                sda_oe    <= 1'b0;
            end else if (stop_det) begin
                state     <= ST_IDLE;
                bitcnt    <= 3'd0;
                byte_full <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        shift     <= {shift[6:0], sda_s2};
                        bitcnt    <= bitcnt + 3'd1;
                        byte_full <= (bitcnt == 3'd7);
                    end
                    ST_RDATA_MACK: begin
                        mstr_ack <= ~sda_s2;
                        if (!sda_s2) begin
                            ptr <= ptr + PTR_ONE;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    ST_ADDR: begin
                        if (byte_full) begin
                            byte_full <= 1'b0;
                            bitcnt    <= 3'd0;
                            if (shift[7:1] == I2C_ADDR) begin
                                state  <= ST_ADDR_ACK;
                                busy   <= 1'b1;
                                sda_oe <= 1'b1;
                                rw_bit <= shift[0];
                            end else begin
                                state <= ST_WAIT;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (rw_bit) begin
                            reg_rd <= 1'b1;
                            shift  <= reg_rdata;
                            sda_oe <= ~reg_rdata[7];
                            bitcnt <= 3'd0;
                            state  <= ST_RDATA;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= ST_PTR;
                        end
                    end
                    ST_PTR: begin
                        if (byte_full) begin
                            byte_full <= 1'b0;
                            bitcnt    <= 3'd0;
                            ptr       <= shift[REG_ADDR_SZ-1:0];
                            sda_oe    <= 1'b1;
                            state     <= ST_PTR_ACK;
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        sda_oe <= 1'b0;
                        state  <= ST_WDATA;
                    end
                    ST_WDATA: begin
                        if (byte_full) begin
                            byte_full <= 1'b0;
                            bitcnt    <= 3'd0;
                            reg_wr    <= 1'b1;
                            reg_wdata <= shift;
                            sda_oe    <= 1'b1;
                            state     <= ST_WDATA_ACK;
                        end
                    end
                    ST_RDATA: begin
                        if (bitcnt == 3'd7) begin
                            sda_oe <= 1'b0;
                            bitcnt <= 3'd0;
                            state  <= ST_RDATA_MACK;
                        end else begin
                            shift  <= {shift[6:0], 1'b0};
                            sda_oe <= ~shift[6];
                            bitcnt <= bitcnt + 3'd1;
                        end
                    end
                    ST_RDATA_MACK: begin
                        if (mstr_ack) begin
                            reg_rd <= 1'b1;
                            shift  <= reg_rdata;
                            sda_oe <= ~reg_rdata[7];
                            bitcnt <= 3'd0;
                            state  <= ST_RDATA;
                        end else begin
                            sda_oe <= 1'b0;
                            busy   <= 1'b0;
                            state  <= ST_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_cfg_target.sv
// tb/tb_i2c_cfg_target.sv - directed bench for i2c_cfg_target
module tb_i2c_cfg_target;

    logic       hsclk;
    logic       resetb;
    logic       scl_drv;
    logic       sda_drv;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [1:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    i2c_cfg_target #(.I2C_ADDR(7'h50), .REG_ADDR_SZ(2)) dut (
        .hsclk     (hsclk),
        .resetb    (resetb),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    initial hsclk = 1'b0;
    always #5 hsclk = ~hsclk;

    assign scl_in    = scl_drv;
    assign sda_in    = sda_drv & ~sda_oe;
    assign reg_rdata = {6'd0, reg_addr} * 8'h11;

    logic [7:0] wr_addr_log [0:63];
    logic [7:0] wr_data_log [0:63];
    logic [7:0] rd_addr_log [0:63];
    int wr_cnt = 0, rd_cnt = 0, oe_cnt = 0, busy_cnt = 0, both_err = 0, long_err = 0;
    logic wr_prev = 1'b0, rd_prev = 1'b0;

    always @(negedge hsclk) begin
        if (reg_wr && wr_cnt < 64) begin
            wr_addr_log[wr_cnt] = {6'd0, reg_addr};
            wr_data_log[wr_cnt] = reg_wdata;
        end
        if (reg_rd && rd_cnt < 64) rd_addr_log[rd_cnt] = {6'd0, reg_addr};
        if (reg_wr) wr_cnt++;
        if (reg_rd) rd_cnt++;
        if (reg_wr && reg_rd) both_err++;
        if ((reg_wr && wr_prev) || (reg_rd && rd_prev)) long_err++;
        wr_prev = reg_wr;
        rd_prev = reg_rd;
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic qwait();
        repeat (8) @(posedge hsclk);
        #2;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; qwait();
        scl_drv = 1'b1; qwait();
        sda_drv = 1'b0; qwait();
        scl_drv = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; qwait();
        scl_drv = 1'b1; qwait();
        sda_drv = 1'b1; qwait();
    endtask

    task automatic write_bit(input logic b);
        sda_drv = b;    qwait();
        scl_drv = 1'b1; qwait();
        qwait();
        scl_drv = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; qwait();
        scl_drv = 1'b1; qwait();
        b = sda_in;     qwait();
        scl_drv = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] data, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(data[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] data, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            data[i] = b;
        end
        write_bit(~mack);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic [7:0] d0, d1, d2;
        logic [7:0] addr_a0;
        int wb, rb, ob, bb;

        addr_a0 = 8'hA0;
        resetb  = 1'b0;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        repeat (3) @(posedge hsclk);
        #2;
        check("rst_sda_oe", sda_oe, 0);
        check("rst_reg_wr", reg_wr, 0);
        check("rst_reg_rd", reg_rd, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_wdata", reg_wdata, 0);
        check("rst_busy", busy, 0);
        resetb = 1'b1;
        qwait();

        // pointer write then two data bytes
        wb = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("t1_ack_addr", ack, 1);
        check("t1_busy_on", busy, 1);
        write_byte(8'h01, ack); check("t1_ack_ptr", ack, 1);
        write_byte(8'h5A, ack); check("t1_ack_d0", ack, 1);
        write_byte(8'h3C, ack); check("t1_ack_d1", ack, 1);
        i2c_stop();
        qwait();
        check("t1_busy_off", busy, 0);
        check("t1_wr_count", wr_cnt - wb, 2);
        check("t1_wr0_addr", wr_addr_log[wb], 8'h01);
        check("t1_wr0_data", wr_data_log[wb], 8'h5A);
        check("t1_wr1_addr", wr_addr_log[wb+1], 8'h02);
        check("t1_wr1_data", wr_data_log[wb+1], 8'h3C);
        check("t1_ptr_after", reg_addr, 3);

        // wrapping read burst via repeated start
        wb = wr_cnt;
        rb = rd_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("t2_ack_addr", ack, 1);
        write_byte(8'h03, ack); check("t2_ack_ptr", ack, 1);
        i2c_start();
        write_byte(8'hA1, ack); check("t2_ack_raddr", ack, 1);
        read_byte(d0, 1'b1);
        read_byte(d1, 1'b1);
        read_byte(d2, 1'b0);
        qwait();
        check("t2_busy_nack", busy, 0);
        check("t2_sda_released", sda_oe, 0);
        i2c_stop();
        check("t2_rdata0", d0, 8'h33);
        check("t2_rdata1", d1, 8'h00);
        check("t2_rdata2", d2, 8'h11);
        check("t2_rd_count", rd_cnt - rb, 3);
        check("t2_rd0_addr", rd_addr_log[rb], 8'h03);
        check("t2_rd1_addr", rd_addr_log[rb+1], 8'h00);
        check("t2_rd2_addr", rd_addr_log[rb+2], 8'h01);
        check("t2_no_wr", wr_cnt - wb, 0);
        check("t2_ptr_after", reg_addr, 1);

        // address mismatch stays silent
        wb = wr_cnt; rb = rd_cnt; ob = oe_cnt; bb = busy_cnt;
        i2c_start();
        write_byte(8'hB0, ack); check("t3_nack_addr", ack, 0);
        write_byte(8'hFF, ack); check("t3_nack_data", ack, 0);
        i2c_stop();
        qwait();
        check("t3_oe_cycles", oe_cnt - ob, 0);
        check("t3_busy_cycles", busy_cnt - bb, 0);
        check("t3_strobes", (wr_cnt - wb) + (rd_cnt - rb), 0);

        // STOP mid-byte discards the partial byte
        wb = wr_cnt;
        i2c_start();
        write_byte(addr_a0, ack); check("t4_ack_addr", ack, 1);
        write_byte(8'h02, ack);   check("t4_ack_ptr", ack, 1);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        qwait();
        check("t4_abort_no_wr", wr_cnt - wb, 0);
        check("t4_abort_busy", busy, 0);
        i2c_start();
        write_byte(addr_a0, ack);
        write_byte(8'h02, ack);
        write_byte(8'h77, ack); check("t4_ack_data", ack, 1);
        i2c_stop();
        qwait();
        check("t4_wr_count", wr_cnt - wb, 1);
        check("t4_wr_addr", wr_addr_log[wb], 8'h02);
        check("t4_wr_data", wr_data_log[wb], 8'h77);

        // pointer carried into a fresh read transaction
        rb = rd_cnt;
        i2c_start();
        write_byte(8'hA1, ack); check("t5_ack_addr", ack, 1);
        read_byte(d0, 1'b0);
        i2c_stop();
        check("t5_rdata", d0, 8'h33);
        check("t5_rd_addr", rd_addr_log[rb], 8'h03);

        // reset while the address ACK is driven
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(addr_a0[i]);
        repeat (2) @(posedge hsclk);
        #2;
        check("t6_ack_driven", sda_oe, 1);
        check("t6_busy_pre", busy, 1);
        #3 resetb = 1'b0;
        #1;
        check("t6_async_oe", sda_oe, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_ptr", reg_addr, 0);
        scl_drv = 1'b1; qwait();
        sda_drv = 1'b1; qwait();
        resetb = 1'b1;
        qwait(); qwait();
        check("t6_post_oe", sda_oe, 0);
        check("t6_post_busy", busy, 0);
        check("t6_post_wdata", reg_wdata, 0);
        rb = rd_cnt;
        i2c_start();
        write_byte(8'hA1, ack); check("t6_ack_raddr", ack, 1);
        read_byte(d0, 1'b0);
        i2c_stop();
        check("t6_rdata", d0, 8'h00);
        check("t6_rd_addr", rd_addr_log[rb], 8'h00);

        check("strobe_overlap", both_err, 0);
        check("strobe_width", long_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
